// File: rtl/uart_pkg.sv
// uart_pkg: shared types and defaults for the UART receive path.
//   uart_rx_state_e   receiver state encoding
//   UART_CLKS_PER_BIT default bit period in clocks (32.256 MHz / 115200)
//   UART_DATA_BITS    default payload width
//   calc_parity()     XOR-reduce helper, payload zero-extended to 9 bits
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    BREAK  = 3'd5
  } uart_rx_state_e;

  localparam int UART_CLKS_PER_BIT = 280;
  localparam int UART_DATA_BITS    = 8;

  function automatic logic calc_parity(input logic [8:0] bits);
    return ^bits;
  endfunction

endpackage

// File: rtl/uart_sync2.sv
// uart_sync2: two-flop synchroniser for a single asynchronous input.
//   RST_VAL  value both stages take during reset
//   clk_i    clock
//   rst_i    asynchronous active-high reset
//   d_i      asynchronous input
//   q_o      synchronised output (two clocks of latency)
module uart_sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_r;
  logic sync_r;

  // Two-stage capture of the asynchronous input.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_r <= RST_VAL;
      sync_r <= RST_VAL;
    end else begin
      meta_r <= d_i;
      sync_r <= meta_r;
    end
  end

  assign q_o = sync_r;

endmodule

// File: rtl/uart_rx_param.sv
// uart_rx_param: parametrised UART receiver with a one-word ready/valid
// holding register, framing check, overrun detection and optional parity.
//
// Build option: define UART_RX_PARITY_EN to add a parity bit after the data
// bits, checked against PARITY_ODD. Without it parity_err_o is always 0.
//
// Ports:
//   clk_i        clock
//   rst_i        asynchronous active-high reset
//   rx_i         asynchronous serial line, idles high
//   data_o       received word (holding register)
//   valid_o      holding register full
//   ready_i      consumer accepts the word when valid_o && ready_i
//   frame_err_o  1-cycle pulse: stop bit sampled low
//   parity_err_o 1-cycle pulse: parity mismatch (word still delivered)
//   overrun_o    1-cycle pulse: completed word dropped, holding reg busy
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int DATA_BITS    = UART_DATA_BITS,
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
  parameter bit PARITY_ODD   = 1'b0
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 rx_i,
  output logic [DATA_BITS-1:0] data_o,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic                 frame_err_o,
  output logic                 parity_err_o,
  output logic                 overrun_o
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(DATA_BITS + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

  logic                 rx_s;
  uart_rx_state_e       state_r;
  logic [CNT_W-1:0]     cnt_r;
  logic [IDX_W-1:0]     idx_r;
  logic [DATA_BITS-1:0] shift_r;
  logic [DATA_BITS-1:0] data_r;
  logic                 valid_r;
  logic                 frame_err_r;
  logic                 overrun_r;

  uart_sync2 #(.RST_VAL(1'b1)) u_sync (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d_i   (rx_i),
    .q_o   (rx_s)
  );

`ifdef UART_RX_PARITY_EN
  logic par_bit_r;
  logic par_err_r;
  logic par_bad_s;

  // Total XOR over payload and parity bit must equal the configured sense.
  assign par_bad_s = (calc_parity(9'(shift_r)) ^ par_bit_r) != PARITY_ODD;
  assign parity_err_o = par_err_r;
`else
  // PARITY_ODD has no effect in this build.
  assign parity_err_o = PARITY_ODD & 1'b0;
`endif

  // Receive FSM, holding register and error pulses.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r     <= IDLE;
      cnt_r       <= {CNT_W{1'b0}};
      idx_r       <= {IDX_W{1'b0}};
      shift_r     <= {DATA_BITS{1'b0}};
      data_r      <= {DATA_BITS{1'b0}};
      valid_r     <= 1'b0;
      frame_err_r <= 1'b0;
      overrun_r   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit_r   <= 1'b0;
      par_err_r   <= 1'b0;
`endif
    end else begin
      frame_err_r <= 1'b0;
      overrun_r   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_err_r   <= 1'b0;
`endif
      // Consumer handshake; a load below on the same cycle takes priority.
      if (valid_r && ready_i) begin
        valid_r <= 1'b0;
      end

      case (state_r)
        IDLE: begin
          if (!rx_s) begin
            cnt_r   <= {CNT_W{1'b0}};
            state_r <= START;
          end
        end

        // Re-check the line mid start bit to reject short glitches.
        START: begin
          if (cnt_r == CNT_HALF) begin
            cnt_r   <= {CNT_W{1'b0}};
            idx_r   <= {IDX_W{1'b0}};
            state_r <= rx_s ? IDLE : DATA;
          end else begin
            cnt_r <= cnt_r + 1'b1;
          end
        end

        // LSB arrives first, so shifting in from the top leaves bit 0 at [0].
        DATA: begin
          if (cnt_r == CNT_LAST) begin
            cnt_r   <= {CNT_W{1'b0}};
            shift_r <= {rx_s, shift_r[DATA_BITS-1:1]};
            if (idx_r == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
              state_r <= PARITY;
`else
              state_r <= STOP;
`endif
            end else begin
              idx_r <= idx_r + 1'b1;
            end
          end else begin
            cnt_r <= cnt_r + 1'b1;
          end
        end

`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (cnt_r == CNT_LAST) begin
            cnt_r     <= {CNT_W{1'b0}};
            par_bit_r <= rx_s;
            state_r   <= STOP;
          end else begin
            cnt_r <= cnt_r + 1'b1;
          end
        end
`endif

        // Returning to IDLE mid stop bit lets back-to-back frames through.
        STOP: begin
          if (cnt_r == CNT_LAST) begin
            cnt_r <= {CNT_W{1'b0}};
            if (rx_s) begin
              if (!valid_r || ready_i) begin
                data_r  <= shift_r;
                valid_r <= 1'b1;
              end else begin
                overrun_r <= 1'b1;
              end
`ifdef UART_RX_PARITY_EN
              par_err_r <= par_bad_s;
`endif
              state_r <= IDLE;
            end else begin
              frame_err_r <= 1'b1;
              state_r     <= BREAK;
            end
          end else begin
            cnt_r <= cnt_r + 1'b1;
          end
        end

        // A held-low line must release before another start bit counts.
        BREAK: begin
          if (rx_s) begin
            state_r <= IDLE;
          end
        end

        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign data_o      = data_r;
  assign valid_o     = valid_r;
  assign frame_err_o = frame_err_r;
  assign overrun_o   = overrun_r;

endmodule

// File: tb/tb_uart_rx_param.sv
// tb_uart_rx_param: directed and randomized frames against a frame-level
// reference model (expected word, pulses and their cycle of occurrence).
module tb_uart_rx_param;

`ifdef UART_RX_PARITY_EN
  localparam int DB  = 7;
  localparam int PAR = 1;
`else
  localparam int DB  = 8;
  localparam int PAR = 0;
`endif
  localparam int C    = 280;
  localparam int H    = C / 2;
  localparam int NB   = DB + PAR;
  localparam bit PODD = 1'b0;

  logic          clk = 1'b0;
  logic          rst;
  logic          rx;
  logic          ready;
  logic [DB-1:0] data_o;
  logic          valid_o;
  logic          frame_err_o;
  logic          parity_err_o;
  logic          overrun_o;

  uart_rx_param #(
    .DATA_BITS    (DB),
    .CLKS_PER_BIT (C),
    .PARITY_ODD   (PODD)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .rx_i         (rx),
    .data_o       (data_o),
    .valid_o      (valid_o),
    .ready_i      (ready),
    .frame_err_o  (frame_err_o),
    .parity_err_o (parity_err_o),
    .overrun_o    (overrun_o)
  );

  always #5 clk = ~clk;

  // Observation counters, updated away from the active edge.
  int            cyc = 0;
  int            vrise = 0, vhigh = 0, ferr = 0, perr = 0, ovr = 0;
  int            vrise_cyc = 0, ferr_cyc = 0, perr_cyc = 0, ovr_cyc = 0;
  int            vrise_data = 0;
  logic          prev_valid = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (valid_o && !prev_valid) begin
      vrise      <= vrise + 1;
      vrise_cyc  <= cyc;
      vrise_data <= int'(data_o);
    end
    prev_valid <= valid_o;
    if (valid_o)      vhigh <= vhigh + 1;
    if (frame_err_o)  begin ferr <= ferr + 1; ferr_cyc <= cyc; end
    if (parity_err_o) begin perr <= perr + 1; perr_cyc <= cyc; end
    if (overrun_o)    begin ovr  <= ovr + 1;  ovr_cyc  <= cyc; end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_val(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model of the holding register.
  bit m_valid = 1'b0;
  int m_data  = 0;

  task automatic set_ready(input bit r);
    ready = r;
    @(negedge clk);
    if (r) m_valid = 1'b0;
    check_val("valid_after_ready", int'(valid_o), int'(m_valid));
    @(negedge clk);
  endtask

  // Drive one frame starting at the current negedge and check its outcome.
  task automatic send_frame(input int data, input bit par_bad, input bit stop_bit);
    int s_vr, s_vh, s_fe, s_pe, s_ov, c0, t_ev, d;
    bit pbit, exp_del, exp_ovr, exp_fe, exp_pe;
    s_vr = vrise; s_vh = vhigh; s_fe = ferr; s_pe = perr; s_ov = ovr;
    d = data & ((1 << DB) - 1);
    exp_del = 1'b0; exp_ovr = 1'b0; exp_fe = 1'b0; exp_pe = 1'b0;
    if (!stop_bit) begin
      exp_fe = 1'b1;
    end else begin
      if (!m_valid || ready) exp_del = 1'b1;
      else                   exp_ovr = 1'b1;
      exp_pe = par_bad && (PAR == 1);
    end
    pbit = (^d) ^ PODD ^ par_bad;
    c0 = cyc;
    rx = 1'b0;
    repeat (C) @(negedge clk);
    for (int k = 0; k < DB; k++) begin
      rx = d[k];
      repeat (C) @(negedge clk);
    end
    if (PAR == 1) begin
      rx = pbit;
      repeat (C) @(negedge clk);
    end
    rx = stop_bit;
    repeat (C) @(negedge clk);
    // Two synchroniser flops plus the IDLE decision precede the bit timeline.
    t_ev = c0 + 3 + H + (NB + 1) * C;
    check_val("word_count", vrise - s_vr, int'(exp_del));
    check_val("overrun_count", ovr - s_ov, int'(exp_ovr));
    check_val("frame_err_count", ferr - s_fe, int'(exp_fe));
    check_val("parity_err_count", perr - s_pe, int'(exp_pe));
    if (exp_del) begin
      check_val("word_data", vrise_data, d);
      check_val("word_cycle", vrise_cyc, t_ev);
      if (ready) check_val("valid_width", vhigh - s_vh, 1);
      m_data  = d;
      m_valid = !ready;
    end
    if (exp_ovr) check_val("overrun_cycle", ovr_cyc, t_ev);
    if (exp_fe)  check_val("frame_err_cycle", ferr_cyc, t_ev);
    if (exp_pe)  check_val("parity_err_cycle", perr_cyc, t_ev);
    check_val("valid_level", int'(valid_o), int'(m_valid));
    if (m_valid) check_val("held_data", int'(data_o), m_data);
  endtask

  task automatic check_reset_outputs();
    check_val("rst_data", int'(data_o), 0);
    check_val("rst_valid", int'(valid_o), 0);
    check_val("rst_frame_err", int'(frame_err_o), 0);
    check_val("rst_parity_err", int'(parity_err_o), 0);
    check_val("rst_overrun", int'(overrun_o), 0);
  endtask

  initial begin
    int s_vr, s_fe;
    bit stop_b, pb;
    rst = 1'b1; rx = 1'b1; ready = 1'b1;
    repeat (5) @(negedge clk);
    check_reset_outputs();
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Plain frame.
    send_frame(32'hA5, 1'b0, 1'b1);

    // Short low glitch must not start a frame.
    s_vr = vrise; s_fe = ferr;
    rx = 1'b0;
    repeat (100) @(negedge clk);
    rx = 1'b1;
    repeat (400) @(negedge clk);
    check_val("glitch_words", vrise - s_vr, 0);
    check_val("glitch_frame_err", ferr - s_fe, 0);
    send_frame(32'h3C, 1'b0, 1'b1);

    // Framing error followed by a long break.
    send_frame(32'h55, 1'b0, 1'b0);
    s_vr = vrise; s_fe = ferr;
    repeat (2000) @(negedge clk);
    rx = 1'b1;
    repeat (50) @(negedge clk);
    check_val("break_words", vrise - s_vr, 0);
    check_val("break_frame_err", ferr - s_fe, 0);
    send_frame(32'h81, 1'b0, 1'b1);

    // Overrun with the consumer stalled, back-to-back frames.
    set_ready(1'b0);
    send_frame(32'h11, 1'b0, 1'b1);
    send_frame(32'h22, 1'b0, 1'b1);
    set_ready(1'b1);

`ifdef UART_RX_PARITY_EN
    send_frame(32'h41, 1'b0, 1'b1);
    send_frame(32'h41, 1'b1, 1'b1);
`endif

    // Randomized frames, consumer readiness and gaps.
    for (int i = 0; i < 10; i++) begin
      set_ready(1'($urandom_range(0, 1)));
      stop_b = ($urandom_range(0, 5) != 0);
      pb     = (PAR == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      send_frame(int'($urandom), pb, stop_b);
      if (!stop_b) begin
        repeat ($urandom_range(0, 200)) @(negedge clk);
        rx = 1'b1;
        repeat (C) @(negedge clk);
      end else begin
        repeat ($urandom_range(0, 1) * $urandom_range(0, C)) @(negedge clk);
      end
    end

    // Reset in the middle of data bit 3 of 0xF0 (bits 0..3 are low).
    set_ready(1'b1);
    set_ready(1'b0);
    send_frame(32'h5A, 1'b0, 1'b1);
    rx = 1'b0;
    repeat (4 * C + H) @(negedge clk);
    rst = 1'b1;
    #1;
    check_reset_outputs();
    m_valid = 1'b0;
    m_data  = 0;
    rx = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    set_ready(1'b1);
    s_vr = vrise;
    send_frame(32'h0F, 1'b0, 1'b1);
    check_val("post_reset_words", vrise - s_vr, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
